// File: rtl/fa16_alloc_ctrl.sv
// 16-way fully-associative allocation controller feeding a PLRU replacement engine.
// Optional macro FA16_ALLOC_INVALID_FIRST_EN: misses fill the lowest invalid way before asking the PLRU.
module fa16_alloc_ctrl #(
    parameter int TAG_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             req_write,
    input  logic             flush,
    output logic             rsp_valid,
    output logic             rsp_hit,
    output logic [3:0]       rsp_way,
    output logic             plru_hit,
    output logic [3:0]       plru_hit_idx,
    output logic             plru_req,
    input  logic [3:0]       plru_replace_idx,
    output logic             evict_valid,
    input  logic             evict_ready,
    output logic [TAG_W-1:0] evict_tag,
    output logic             refill_valid,
    input  logic             refill_ready,
    output logic [TAG_W-1:0] refill_tag
);

    typedef enum logic [1:0] {IDLE, CHECK, EVICT, REFILL} state_t;

    state_t           state;
    logic [TAG_W-1:0] tags [16];
    logic [15:0]      valid;
    logic [15:0]      dirty;
    logic [TAG_W-1:0] lat_tag;
    logic             lat_write;
    logic [3:0]       way;
    logic             from_inv;

    logic             hit;
    logic [3:0]       hit_way;
    logic             use_inv;
    logic             in_check_hit;
    logic             refill_done;

    // Install never duplicates a tag, so at most one way matches.
    always_comb begin
        hit     = 1'b0;
        hit_way = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (valid[i] && (tags[i] == lat_tag)) begin
                hit     = 1'b1;
                hit_way = 4'(i);
            end
        end
    end

`ifdef FA16_ALLOC_INVALID_FIRST_EN
    logic [3:0] inv_way;
    always_comb begin
        inv_way = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (!valid[i]) inv_way = 4'(i);
        end
    end
    assign use_inv = ~&valid;
`else
    assign use_inv = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            valid     <= '0;
            dirty     <= '0;
            lat_tag   <= '0;
            lat_write <= 1'b0;
            way       <= 4'd0;
            from_inv  <= 1'b0;
            for (int i = 0; i < 16; i++) tags[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush) begin
                        valid <= '0;
                        dirty <= '0;
                    end else if (req_valid) begin
                        lat_tag   <= req_tag;
                        lat_write <= req_write;
                        state     <= CHECK;
                    end
                end
                CHECK: begin
                    if (hit) begin
                        dirty[hit_way] <= dirty[hit_way] | lat_write;
                        state          <= IDLE;
                    end else if (use_inv) begin
`ifdef FA16_ALLOC_INVALID_FIRST_EN
                        way      <= inv_way;
`endif
                        from_inv <= 1'b1;
                        state    <= REFILL;
                    end else begin
                        way      <= plru_replace_idx;
                        from_inv <= 1'b0;
                        if (valid[plru_replace_idx] && dirty[plru_replace_idx])
                            state <= EVICT;
                        else
                            state <= REFILL;
                    end
                end
                EVICT: begin
                    if (evict_ready) begin
                        valid[way] <= 1'b0;
                        state      <= REFILL;
                    end
                end
                REFILL: begin
                    if (refill_ready) begin
                        tags[way]  <= lat_tag;
                        valid[way] <= 1'b1;
                        dirty[way] <= lat_write;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Responses fire in the handshake cycle itself, so outputs decode state plus ready.
    assign in_check_hit = (state == CHECK) && hit;
    assign refill_done  = (state == REFILL) && refill_ready;

    assign req_ready    = (state == IDLE) && !flush;
    assign rsp_valid    = in_check_hit || refill_done;
    assign rsp_hit      = in_check_hit;
    assign rsp_way      = in_check_hit ? hit_way : (refill_done ? way : 4'd0);
    assign plru_hit     = in_check_hit || (refill_done && from_inv);
    assign plru_hit_idx = in_check_hit ? hit_way : ((refill_done && from_inv) ? way : 4'd0);
    assign plru_req     = (state == CHECK) && !hit && !use_inv;
    assign evict_valid  = (state == EVICT);
    assign evict_tag    = (state == EVICT) ? tags[way] : '0;
    assign refill_valid = (state == REFILL);
    assign refill_tag   = (state == REFILL) ? lat_tag : '0;

endmodule
